// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-to-host frame receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    // start + 8 data + parity + stop
    localparam int PS2_FRAME_BITS  = 11;
    localparam int DEF_FILTER_LEN  = 8;
    localparam int DEF_TIMEOUT_CYC = 50000;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx_frame_if.sv
// Pin-side and byte-side signals of the PS/2 receiver; master drives the pins,
// slave is the receiver itself.
interface ps2_rx_frame_if;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       rx_en;
    logic [7:0] data;
    logic       valid;
    logic       par_err;
    logic       frm_err;
    logic       busy;

    modport master (
        output ps2_clk, ps2_dat, rx_en,
        input  data, valid, par_err, frm_err, busy
    );

    modport slave (
        input  ps2_clk, ps2_dat, rx_en,
        output data, valid, par_err, frm_err, busy
    );
endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus a FILTER_LEN-sample glitch filter for an async pin.
// Emits the filtered level and a one-cycle strobe on each filtered 1->0 transition.
module ps2_line_filter #(
    parameter int FILTER_LEN = ps2_pkg::DEF_FILTER_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic fall
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          fall_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pin};
            fall_q <= 1'b0;
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                // Final disagreeing sample: adopt the new level, strobe if it is a fall.
                cnt_q   <= '0;
                level_q <= sync_q[1];
                fall_q  <= level_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level = level_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host receiver: one byte per valid 11-bit frame, parity/framing flags.
// Optional watchdog enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = DEF_FILTER_LEN,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic          iCLK_50,
    input  logic          iRST_n,
    ps2_rx_frame_if.slave bus
);
    localparam int DATA_BITS = PS2_FRAME_BITS - 3;

    ps2_state_e state_q, state_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic       par_q, par_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       par_err_q, par_err_d;
    logic       frm_err_q, frm_err_d;

    logic       clk_level;
    logic       clk_fall;
    logic [1:0] dat_sync_q;
    logic       dat;
    logic       timeout;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (iCLK_50),
        .rst_n (iRST_n),
        .pin   (bus.ps2_clk),
        .level (clk_level),
        .fall  (clk_fall)
    );

    // Data is only sampled on filtered clock falls, so synchronising suffices.
    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
        if (!iRST_n) dat_sync_q <= 2'b11;
        else         dat_sync_q <= {dat_sync_q[0], bus.ps2_dat};
    end
    assign dat = dat_sync_q[1];

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] timer_q;

    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            timer_q <= '0;
        end else if (!bus.rx_en || state_q == IDLE || clk_fall || timeout) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + 1'b1;
        end
    end

    assign timeout = (state_q != IDLE) && (timer_q == TW'(TIMEOUT_CYC - 1));
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q   <= IDLE;
            bitcnt_q  <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        par_err_d = 1'b0;
        frm_err_d = 1'b0;

        if (!bus.rx_en) begin
            // Host inhibit: drop any partial frame silently.
            state_d  = IDLE;
            bitcnt_d = '0;
            shreg_d  = '0;
        end else if (clk_fall) begin
            unique case (state_q)
                IDLE: begin
                    if (!dat) begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                        shreg_d  = '0;
                    end
                end
                DATA: begin
                    shreg_d  = {dat, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == 3'(DATA_BITS - 1)) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = dat;
                    state_d = STOP;
                end
                STOP: begin
                    if (!dat)                               frm_err_d = 1'b1;
                    else if (!odd_parity_ok(shreg_q, par_q)) par_err_d = 1'b1;
                    else begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (timeout) begin
            state_d   = IDLE;
            bitcnt_d  = '0;
            shreg_d   = '0;
            frm_err_d = 1'b1;
        end
    end

    assign bus.data    = data_q;
    assign bus.valid   = valid_q;
    assign bus.par_err = par_err_q;
    assign bus.frm_err = frm_err_q;
    assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame: table of whole frames plus hand-written
// glitch, inhibit, timeout and reset sequences. Honours PS2_RX_TIMEOUT_EN.
module tb_ps2_rx_frame;
    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 2000;
    localparam int HALF        = 40;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ps2_rx_frame_if bus ();

    ps2_rx_frame #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .iCLK_50 (clk),
        .iRST_n  (rst_n),
        .bus     (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cnt_valid = 0, cnt_par = 0, cnt_frm = 0, cnt_multi = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.valid)   cnt_valid++;
            if (bus.par_err) cnt_par++;
            if (bus.frm_err) cnt_frm++;
            if (int'(bus.valid) + int'(bus.par_err) + int'(bus.frm_err) > 1) cnt_multi++;
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d, input logic p, input logic s);
        return {s, p, d, 1'b0};
    endfunction

    // Sends the first n bits of a frame, LSB (start bit) first.
    task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.ps2_dat = bits[i];
            if (glitch) begin
                idle(10); bus.ps2_clk = 1'b0; idle(5); bus.ps2_clk = 1'b1; idle(HALF - 15);
            end else idle(HALF);
            bus.ps2_clk = 1'b0;
            if (glitch) begin
                idle(10); bus.ps2_clk = 1'b1; idle(5); bus.ps2_clk = 1'b0; idle(HALF - 15);
            end else idle(HALF);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_dat = 1'b1;
    endtask

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       s;
        int         ev;
        int         ep;
        int         ef;
        logic [7:0] edata;
    } vec_t;

    vec_t vecs[8];
    int   v0, p0, f0;

    task automatic snap();
        v0 = cnt_valid; p0 = cnt_par; f0 = cnt_frm;
    endtask

    task automatic check_deltas(input string tag, input int ev, input int ep, input int ef);
        check({tag, " valid"},   cnt_valid - v0, ev);
        check({tag, " par_err"}, cnt_par - p0,   ep);
        check({tag, " frm_err"}, cnt_frm - f0,   ef);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vecs[0] = '{8'hFA, 1'b1, 1'b1, 1, 0, 0, 8'hFA};
        vecs[1] = '{8'h08, 1'b1, 1'b1, 0, 1, 0, 8'hFA};
        vecs[2] = '{8'h55, 1'b1, 1'b0, 0, 0, 1, 8'hFA};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 1, 0, 0, 8'h00};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 1, 0, 0, 8'hFF};
        vecs[5] = '{8'h81, 1'b0, 1'b1, 0, 1, 0, 8'hFF};
        vecs[6] = '{8'h6E, 1'b1, 1'b0, 0, 0, 1, 8'hFF};
        vecs[7] = '{8'h01, 1'b0, 1'b1, 1, 0, 0, 8'h01};

        bus.ps2_clk = 1'b1;
        bus.ps2_dat = 1'b1;
        bus.rx_en   = 1'b1;
        idle(5);
        check("reset data",  int'(bus.data),  0);
        check("reset valid", int'(bus.valid), 0);
        check("reset busy",  int'(bus.busy),  0);
        rst_n = 1'b1;
        idle(20);

        for (int i = 0; i < 8; i++) begin
            snap();
            send_bits(frame(vecs[i].d, vecs[i].p, vecs[i].s), 11, 1'b0);
            idle(30);
            check_deltas($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ep, vecs[i].ef);
            check($sformatf("vec%0d data", i), int'(bus.data), int'(vecs[i].edata));
            check($sformatf("vec%0d busy", i), int'(bus.busy), 0);
        end

        // Short clock glitches while idle and inside a frame.
        snap();
        for (int i = 0; i < 3; i++) begin
            bus.ps2_clk = 1'b0; idle(5); bus.ps2_clk = 1'b1; idle(20);
        end
        idle(20);
        check("idle glitch busy", int'(bus.busy), 0);
        send_bits(frame(8'h3C, 1'b1, 1'b1), 11, 1'b1);
        idle(30);
        check_deltas("glitch", 1, 0, 0);
        check("glitch data", int'(bus.data), 'h3C);

        // Host inhibit after four data bits, then a clean frame.
        snap();
        send_bits(frame(8'h99, 1'b1, 1'b1), 5, 1'b0);
        idle(5);
        check("inhibit busy before", int'(bus.busy), 1);
        bus.rx_en = 1'b0;
        idle(2);
        check("inhibit busy after", int'(bus.busy), 0);
        idle(50);
        bus.rx_en = 1'b1;
        idle(20);
        check_deltas("inhibit", 0, 0, 0);
        snap();
        send_bits(frame(8'hAA, 1'b1, 1'b1), 11, 1'b0);
        idle(30);
        check_deltas("reenable", 1, 0, 0);
        check("reenable data", int'(bus.data), 'hAA);

        // Clocks stop after five bits.
        snap();
        send_bits(frame(8'hC3, 1'b1, 1'b1), 5, 1'b0);
        idle(TIMEOUT_CYC - 200);
        check("stall busy early", int'(bus.busy), 1);
        check("stall frm early", cnt_frm - f0, 0);
        idle(400);
`ifdef PS2_RX_TIMEOUT_EN
        check("timeout frm_err", cnt_frm - f0, 1);
        check("timeout busy",    int'(bus.busy), 0);
`else
        check("stall frm_err", cnt_frm - f0, 0);
        check("stall busy",    int'(bus.busy), 1);
        bus.rx_en = 1'b0; idle(5); bus.rx_en = 1'b1; idle(5);
`endif
        check("stall valid", cnt_valid - v0, 0);
        snap();
        send_bits(frame(8'h01, 1'b0, 1'b1), 11, 1'b0);
        idle(30);
        check_deltas("after stall", 1, 0, 0);
        check("after stall data", int'(bus.data), 'h01);

        // Asynchronous reset mid-frame.
        send_bits(frame(8'h5A, 1'b1, 1'b1), 3, 1'b0);
        idle(5);
        check("pre-reset busy", int'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid reset busy",    int'(bus.busy),    0);
        check("mid reset data",    int'(bus.data),    0);
        check("mid reset valid",   int'(bus.valid),   0);
        check("mid reset par_err", int'(bus.par_err), 0);
        check("mid reset frm_err", int'(bus.frm_err), 0);
        idle(5);
        rst_n = 1'b1;
        idle(10);

        check("pulse overlap", cnt_multi, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
